// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port and a
// per-register pending-write scoreboard; entry 0 is hardwired to zero.
module regfile_scoreboard #(
    parameter int          WIDTH  = 32,
    parameter int          ADDR_W = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data2,
    output logic              rd_busy2
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0]  mem_r [DEPTH];
    logic [DEPTH-1:1]  busy_r;
    logic [DEPTH-1:0]  busy_vec_s;
    logic              wr_ok_s;
    logic              rsv_ok_s;
    logic [ADDR_W-1:0] rd_addr_s [2];
    logic [WIDTH-1:0]  rd_data_s [2];
    logic              rd_busy_s [2];

    assign wr_ok_s    = wr_en && (wr_addr != '0);
    assign rsv_ok_s   = rsv_en && (rsv_addr != '0);
    assign busy_vec_s = {busy_r, 1'b0};

    assign rd_addr_s[0] = rd_addr1;
    assign rd_addr_s[1] = rd_addr2;
    assign rd_data1     = rd_data_s[0];
    assign rd_busy1     = rd_busy_s[0];
    assign rd_data2     = rd_data_s[1];
    assign rd_busy2     = rd_busy_s[1];

    // Data storage: entry 0 is never written, so it holds its reset value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Scoreboard: a reserve on the same edge as the write-back wins, since a
    // newer producer has been issued for that register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= '0;
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (rsv_ok_s && (rsv_addr == ADDR_W'(i))) begin
                    busy_r[i] <= 1'b1;
                end else if (wr_ok_s && (wr_addr == ADDR_W'(i))) begin
                    busy_r[i] <= 1'b0;
                end
            end
        end
    end

    // Read ports: the forward path is gated by reset so nothing leaks while held.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data_s[p] = '0;
            rd_busy_s[p] = 1'b0;
            if (!reset_n || (rd_addr_s[p] == '0)) begin
                rd_data_s[p] = '0;
                rd_busy_s[p] = 1'b0;
            end else if ((BYPASS != 32'd0) && wr_en && (wr_addr == rd_addr_s[p])) begin
                rd_data_s[p] = wr_data;
                rd_busy_s[p] = 1'b0;
            end else begin
                rd_data_s[p] = mem_r[rd_addr_s[p]];
                rd_busy_s[p] = busy_vec_s[rd_addr_s[p]];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// array-based reference model, on BYPASS=1, BYPASS=0 and an 8x8 instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        wr_en, rsv_en;
    logic [4:0]  wr_addr, rsv_addr, rd_addr1, rd_addr2;
    logic [31:0] wr_data;
    logic [31:0] d1_p, d2_p, d1_n, d2_n;
    logic        y1_p, y2_p, y1_n, y2_n;

    logic        s_wr_en, s_rsv_en;
    logic [2:0]  s_wr_addr, s_rsv_addr, s_rd_addr1, s_rd_addr2;
    logic [7:0]  s_wr_data, s_d1, s_d2;
    logic        s_y1, s_y2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];

    regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_data1(d1_p), .rd_busy1(y1_p),
        .rd_addr2(rd_addr2), .rd_data2(d2_p), .rd_busy2(y2_p));

    regfile_scoreboard #(.WIDTH(32), .ADDR_W(5), .BYPASS(0)) u_nobyp (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rd_addr1(rd_addr1), .rd_data1(d1_n), .rd_busy1(y1_n),
        .rd_addr2(rd_addr2), .rd_data2(d2_n), .rd_busy2(y2_n));

    regfile_scoreboard #(.WIDTH(8), .ADDR_W(3), .BYPASS(1)) u_small (
        .clk(clk), .reset_n(reset_n), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
        .rsv_en(s_rsv_en), .rsv_addr(s_rsv_addr),
        .rd_addr1(s_rd_addr1), .rd_data1(s_d1), .rd_busy1(s_y1),
        .rd_addr2(s_rd_addr2), .rd_data2(s_d2), .rd_busy2(s_y2));

    task automatic idle();
        wr_en = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
        rsv_en = 1'b0; rsv_addr = 5'd0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Reference rule set: write lands and clears busy, then a reserve sets busy.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (wr_en && wr_addr != 5'd0) begin
                m_mem[wr_addr]  = wr_data;
                m_busy[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 5'd0) m_busy[rsv_addr] = 1'b1;
        end
        #1;
    endtask

    function automatic logic [32:0] exp_read(input bit byp, input logic [4:0] a);
        if (!reset_n || a == 5'd0) return 33'd0;
        if (byp && wr_en && wr_addr == a) return {wr_data, 1'b0};
        return {m_mem[a], m_busy[a]};
    endfunction

    task automatic test_reset();
        idle();
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'hFFFF_0000;
        rsv_en = 1'b1; rsv_addr = 5'd4; rd_addr1 = 5'd4; rd_addr2 = 5'd4;
        #1;
        n_checks++;
        if ({d1_p, y1_p, d2_p, y2_p, d1_n, y1_n, d2_n, y2_n} !== 132'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h %b %h %b / %h %b %h %b, expected all zero",
                     d1_p, y1_p, d2_p, y2_p, d1_n, y1_n, d2_n, y2_n);
        end
        idle();
        @(negedge clk); reset_n = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
        tick();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        idle(); rd_addr1 = 5'd5;
        #1;
        n_checks++;
        if (d1_p !== 32'hDEAD_BEEF || y1_p !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_r5: got %h busy %b, expected deadbeef busy 1", d1_p, y1_p);
        end
        @(negedge clk); #1;
        reset_n = 1'b0; model_clear();
        #1;
        n_checks++;
        if ({d1_p, y1_p, d1_n, y1_n} !== 66'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %h %b / %h %b, expected zero", d1_p, y1_p, d1_n, y1_n);
        end
        #1 reset_n = 1'b1;
        #1;
        n_checks++;
        if ({d1_p, y1_p} !== 33'd0) begin
            n_fail++;
            $display("FAIL post_reset_r5: got %h busy %b, expected 0 busy 0", d1_p, y1_p);
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0032; rd_addr1 = 5'd3;
        #1;
        n_checks++;
        if (d1_n !== 32'd0) begin
            n_fail++;
            $display("FAIL nobyp_same_cycle: got %h, expected 00000000", d1_n);
        end
        n_checks++;
        if (d1_p !== 32'h32 || y1_p !== 1'b0) begin
            n_fail++;
            $display("FAIL byp_same_cycle: got %h busy %b, expected 00000032 busy 0", d1_p, y1_p);
        end
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (d1_n !== 32'h32 || d1_p !== 32'h32) begin
            n_fail++;
            $display("FAIL write_after_edge: got %h / %h, expected 00000032", d1_n, d1_p);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF;
        rsv_en = 1'b1; rsv_addr = 5'd0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if ({d1_p, y1_p, d2_p, y2_p, d1_n, y1_n, d2_n, y2_n} !== 132'd0) begin
                n_fail++;
                $display("FAIL zero_reg cycle %0d: got %h %b %h %b / %h %b %h %b, expected all zero",
                         c, d1_p, y1_p, d2_p, y2_p, d1_n, y1_n, d2_n, y2_n);
            end
            tick();
        end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1'b1; rsv_addr = 5'd7; rd_addr2 = 5'd7;
        tick();
        rsv_en = 1'b0;
        #1;
        n_checks++;
        if (y2_p !== 1'b1 || y2_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reserve_busy: got %b / %b, expected 1", y2_p, y2_n);
        end
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_1234;
        #1;
        n_checks++;
        if (d2_p !== 32'h1234 || y2_p !== 1'b0) begin
            n_fail++;
            $display("FAIL forward_wb: got %h busy %b, expected 00001234 busy 0", d2_p, y2_p);
        end
        n_checks++;
        if (d2_n !== 32'd0 || y2_n !== 1'b1) begin
            n_fail++;
            $display("FAIL nobyp_wb_cycle: got %h busy %b, expected 0 busy 1", d2_n, y2_n);
        end
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if ({d2_p, y2_p, d2_n, y2_n} !== {32'h1234, 1'b0, 32'h1234, 1'b0}) begin
            n_fail++;
            $display("FAIL wb_landed: got %h %b / %h %b, expected 00001234 0", d2_p, y2_p, d2_n, y2_n);
        end
    endtask

    task automatic test_collision();
        idle();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5_A5A5;
        rsv_en = 1'b1; rsv_addr = 5'd9; rd_addr1 = 5'd9;
        tick();
        idle(); rd_addr1 = 5'd9;
        #1;
        n_checks++;
        if (d1_p !== 32'hA5A5_A5A5 || y1_p !== 1'b1 || y1_n !== 1'b1) begin
            n_fail++;
            $display("FAIL collision: got %h busy %b/%b, expected a5a5a5a5 busy 1", d1_p, y1_p, y1_n);
        end
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        tick();
        rsv_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0077;
        tick();
        wr_en = 1'b0;
        #1;
        n_checks++;
        if (d1_n !== 32'h77 || y1_n !== 1'b0) begin
            n_fail++;
            $display("FAIL rereserve_not_counter: got %h busy %b, expected 00000077 busy 0", d1_n, y1_n);
        end
    endtask

    task automatic test_random();
        logic [32:0] e1p, e2p, e1n, e2n;
        for (int it = 0; it < 400; it++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            wr_data  = $urandom;
            rsv_en   = 1'($urandom_range(0, 2) == 0);
            rsv_addr = 5'($urandom_range(0, 1) == 0 ? wr_addr : 5'($urandom_range(0, 7)));
            rd_addr1 = 5'($urandom_range(0, 2) == 0 ? wr_addr : 5'($urandom_range(0, 7)));
            rd_addr2 = 5'($urandom_range(0, 2) == 0 ? rsv_addr : 5'($urandom_range(0, 31)));
            #1;
            e1p = exp_read(1'b1, rd_addr1); e2p = exp_read(1'b1, rd_addr2);
            e1n = exp_read(1'b0, rd_addr1); e2n = exp_read(1'b0, rd_addr2);
            n_checks++;
            if ({d1_p, y1_p, d2_p, y2_p} !== {e1p, e2p}) begin
                n_fail++;
                $display("FAIL random_byp it %0d a1=%0d a2=%0d: got %h %b %h %b, expected %h %h",
                         it, rd_addr1, rd_addr2, d1_p, y1_p, d2_p, y2_p, e1p, e2p);
            end
            n_checks++;
            if ({d1_n, y1_n, d2_n, y2_n} !== {e1n, e2n}) begin
                n_fail++;
                $display("FAIL random_nobyp it %0d a1=%0d a2=%0d: got %h %b %h %b, expected %h %h",
                         it, rd_addr1, rd_addr2, d1_n, y1_n, d2_n, y2_n, e1n, e2n);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_sweep();
        logic [7:0] ea, eb;
        for (int i = 1; i < 8; i++) begin
            s_wr_en = 1'b1; s_wr_addr = 3'(i); s_wr_data = 8'(i * 17);
            tick();
        end
        s_wr_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                s_rd_addr1 = 3'(a); s_rd_addr2 = 3'(b);
                #1;
                ea = 8'(a * 17); eb = 8'(b * 17);
                n_checks++;
                if ({s_d1, s_y1, s_d2, s_y2} !== {ea, 1'b0, eb, 1'b0}) begin
                    n_fail++;
                    $display("FAIL sweep a=%0d b=%0d: got %h %b %h %b, expected %h 0 %h 0",
                             a, b, s_d1, s_y1, s_d2, s_y2, ea, eb);
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        s_wr_en = 1'b0; s_wr_addr = 3'd0; s_wr_data = 8'd0;
        s_rsv_en = 1'b0; s_rsv_addr = 3'd0; s_rd_addr1 = 3'd0; s_rd_addr2 = 3'd0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_zero_reg();
        test_scoreboard();
        test_collision();
        test_random();
        test_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
